// File: rtl/instr_encoder_if.sv
// Request and output handshakes of the ALU-op to MIPS word encoder.
// master drives requests and takes words; slave is the encoder.
interface instr_encoder_if #(
    parameter int ADDR_W = 6
);
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_kind;
    logic [2:0]        req_alu;
    logic [4:0]        req_rs;
    logic [4:0]        req_rt;
    logic [4:0]        req_rd;
    logic [15:0]       req_imm;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [ADDR_W-1:0] out_addr;

    modport master (
        output req_valid, req_kind, req_alu,
        output req_rs, req_rt, req_rd, req_imm,
        output out_ready,
        input  req_ready, out_valid,
        input  out_instr, out_addr
    );

    modport slave (
        input  req_valid, req_kind, req_alu,
        input  req_rs, req_rt, req_rd, req_imm,
        input  out_ready,
        output req_ready, out_valid,
        output out_instr, out_addr
    );
endinterface

// File: rtl/instr_encoder.sv
// Turns an ALU-level request into a MIPS instruction word with a
// sequential load address; one-entry output register, valid/ready.
module instr_encoder #(
    parameter int              ADDR_W    = 6,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flush,
    instr_encoder_if.slave bus,
    output logic err
);
    localparam logic [2:0] K_RALU = 3'd0;
    localparam logic [2:0] K_IALU = 3'd1;
    localparam logic [2:0] K_LW   = 3'd2;
    localparam logic [2:0] K_SW   = 3'd3;
    localparam logic [2:0] K_BEQ  = 3'd4;
    localparam logic [2:0] K_BNE  = 3'd5;
    localparam logic [2:0] K_JR   = 3'd6;

    typedef enum logic {
        EMPTY,
        FULL
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [31:0]       word;
    logic              word_ok;
    logic [5:0]        funct;
    logic [5:0]        iop;
    logic              alu_ok;
    logic              acc;
    logic              load;
    logic [31:0]       instr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] cnt_q;
    logic              err_q;

    always_comb begin
        funct = 6'b000000;
        iop   = 6'b000000;
        alu_ok = 1'b1;
        unique case (bus.req_alu)
            3'b010: begin funct = 6'b100000; iop = 6'b001000; end
            3'b110: funct = 6'b100010;
            3'b000: begin funct = 6'b100100; iop = 6'b001100; end
            3'b001: begin funct = 6'b100101; iop = 6'b001101; end
            3'b011: funct = 6'b100110;
            3'b111: funct = 6'b101010;
            default: alu_ok = 1'b0;
        endcase
    end

    // I-ALU only has immediate forms for add/and/or
    always_comb begin
        word    = 32'h0;
        word_ok = 1'b0;
        unique case (1'b1)
            (bus.req_kind == K_RALU): begin
                word_ok = alu_ok;
                word = {6'b000000, bus.req_rs, bus.req_rt,
                        bus.req_rd, 5'b00000, funct};
            end
            (bus.req_kind == K_IALU): begin
                word_ok = (iop != 6'b000000);
                word = {iop, bus.req_rs, bus.req_rt, bus.req_imm};
            end
            (bus.req_kind == K_LW): begin
                word_ok = 1'b1;
                word = {6'b100011, bus.req_rs, bus.req_rt, bus.req_imm};
            end
            (bus.req_kind == K_SW): begin
                word_ok = 1'b1;
                word = {6'b101011, bus.req_rs, bus.req_rt, bus.req_imm};
            end
            (bus.req_kind == K_BEQ): begin
                word_ok = 1'b1;
                word = {6'b000100, bus.req_rs, bus.req_rt, bus.req_imm};
            end
            (bus.req_kind == K_BNE): begin
                word_ok = 1'b1;
                word = {6'b000101, bus.req_rs, bus.req_rt, bus.req_imm};
            end
            (bus.req_kind == K_JR): begin
                word_ok = 1'b1;
                word = {6'b000000, bus.req_rs, 15'h0, 6'b001000};
            end
            default: begin
                word_ok = 1'b0;
                word    = 32'h0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n       = state;
        bus.req_ready = ~flush & ((state == EMPTY) | bus.out_ready);
        acc           = bus.req_valid & bus.req_ready;
        load          = acc & word_ok;
        if (flush) begin
            state_n = EMPTY;
        end else if (load) begin
            state_n = FULL;
        end else if ((state == FULL) && bus.out_ready) begin
            state_n = EMPTY;
        end
    end

    // flush blocks acceptance, so err clears on its own
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q <= 32'h0;
            addr_q  <= BASE_ADDR;
            cnt_q   <= BASE_ADDR;
            err_q   <= 1'b0;
        end else begin
            err_q <= acc & ~word_ok;
            if (flush) begin
                cnt_q <= BASE_ADDR;
            end else if (load) begin
                instr_q <= word;
                addr_q  <= cnt_q;
                cnt_q   <= cnt_q + 1'b1;
            end
        end
    end

    assign bus.out_valid = (state == FULL);
    assign bus.out_instr = instr_q;
    assign bus.out_addr  = addr_q;
    assign err           = err_q;
endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: directed cases plus random traffic
// against a table-driven encoding model.
module tb_instr_encoder;
    localparam int AW = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic err;

    instr_encoder_if #(.ADDR_W(AW)) bus ();

    instr_encoder #(
        .ADDR_W(AW),
        .BASE_ADDR(2'd0)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .flush(flush),
        .bus(bus.slave),
        .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]   w;
        logic [AW-1:0] a;
    } exp_t;

    exp_t sbq[$];
    int   errq[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   mcnt = 0;
    bit   rr = 1'b0;

    // -1 marks an encoding that does not exist
    int rf[8] = '{32'h24, 32'h25, 32'h20, 32'h26, -1, -1, 32'h22, 32'h2A};
    int io[8] = '{32'h0C, 32'h0D, 32'h08, -1, -1, -1, -1, -1};
    int mo[8] = '{-1, -1, 32'h23, 32'h2B, 32'h04, 32'h05, -1, -1};

    function automatic bit model(input int k, input int alu, input int rs,
                                 input int rt, input int rd, input int imm,
                                 output logic [31:0] w);
        logic [31:0] f;
        w = 32'h0;
        f = (32'(rs) << 21) | (32'(rt) << 16);
        if (k == 0) begin
            if (rf[alu] < 0) return 1'b0;
            w = f | (32'(rd) << 11) | 32'(rf[alu]);
        end else if (k == 1) begin
            if (io[alu] < 0) return 1'b0;
            w = (32'(io[alu]) << 26) | f | 32'(imm);
        end else if (k >= 2 && k <= 5) begin
            w = (32'(mo[k]) << 26) | f | 32'(imm);
        end else if (k == 6) begin
            w = (32'(rs) << 21) | 32'h8;
        end else begin
            return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic monitor();
        bit            hv;
        bit            ee;
        logic [31:0]   hi;
        logic [AW-1:0] ha;
        exp_t          e;
        hv = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                hv = 1'b0;
                continue;
            end
            ee = (errq.size() > 0) && (errq[0] == cyc);
            if (ee) errq.delete(0);
            chk("err", err, ee);
            if (hv) begin
                chk("hold_valid", bus.out_valid, 1);
                chk("hold_instr", bus.out_instr, hi);
                chk("hold_addr", bus.out_addr, ha);
            end
            if (flush) begin
                chk("flush_ready", bus.req_ready, 0);
                sbq.delete();
                hv = 1'b0;
                continue;
            end
            chk("req_ready", bus.req_ready,
                !bus.out_valid || bus.out_ready);
            if (bus.out_valid) begin
                chk("spurious_word", sbq.size() > 0, 1);
                if (bus.out_ready && sbq.size() > 0) begin
                    e = sbq.pop_front();
                    chk("instr", bus.out_instr, e.w);
                    chk("addr", bus.out_addr, e.a);
                end
            end
            hv = bus.out_valid && !bus.out_ready;
            hi = bus.out_instr;
            ha = bus.out_addr;
        end
    endtask

    task automatic issue(input logic [2:0] k, input logic [2:0] alu,
                         input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [15:0] imm,
                         input bit ok, input logic [31:0] w);
        bus.req_valid = 1'b1;
        bus.req_kind  = k;
        bus.req_alu   = alu;
        bus.req_rs    = rs;
        bus.req_rt    = rt;
        bus.req_rd    = rd;
        bus.req_imm   = imm;
        for (int i = 0; ; i++) begin
            @(negedge clk);
            #1;
            if (bus.req_ready) break;
            if (i == 200) begin
                chk("accept_timeout", 0, 1);
                bus.req_valid = 1'b0;
                return;
            end
        end
        if (ok) begin
            sbq.push_back('{w: w, a: AW'(mcnt)});
            mcnt = (mcnt + 1) % (1 << AW);
        end else begin
            errq.push_back(cyc + 1);
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic send(input logic [2:0] k, input logic [2:0] alu,
                        input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [15:0] imm);
        logic [31:0] w;
        bit ok;
        ok = model(int'(k), int'(alu), int'(rs), int'(rt), int'(rd),
                   int'(imm), w);
        issue(k, alu, rs, rt, rd, imm, ok, w);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_flush(input bit with_req);
        flush = 1'b1;
        if (with_req) begin
            bus.req_valid = 1'b1;
            bus.req_kind  = 3'd0;
            bus.req_alu   = 3'b010;
        end
        @(posedge clk);
        #1;
        flush = 1'b0;
        bus.req_valid = 1'b0;
        mcnt = 0;
        chk("flush_empty", bus.out_valid, 0);
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_kind  = '0;
        bus.req_alu   = '0;
        bus.req_rs    = '0;
        bus.req_rt    = '0;
        bus.req_rd    = '0;
        bus.req_imm   = '0;
        bus.out_ready = 1'b1;
        fork
            monitor();
        join_none

        #2;
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_instr", bus.out_instr, 0);
        chk("rst_addr", bus.out_addr, 0);
        chk("rst_err", err, 0);
        chk("rst_ready", bus.req_ready, 1);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);

        issue(3'd0, 3'b010, 5'd1, 5'd2, 5'd3, 16'h0, 1, 32'h00221820);
        idle(2);

        do_flush(0);
        issue(3'd2, 3'b000, 5'd29, 5'd8, 5'd0, 16'h0004, 1, 32'h8FA80004);
        issue(3'd4, 3'b000, 5'd1, 5'd2, 5'd0, 16'hFFFF, 1, 32'h1022FFFF);
        issue(3'd6, 3'b000, 5'd31, 5'd0, 5'd0, 16'h0, 1, 32'h03E00008);
        issue(3'd1, 3'b001, 5'd0, 5'd5, 5'd0, 16'h00FF, 1, 32'h340500FF);
        idle(2);

        do_flush(0);
        bus.out_ready = 1'b0;
        send(3'd0, 3'b010, 5'd4, 5'd5, 5'd6, 16'h0);
        fork
            send(3'd0, 3'b010, 5'd7, 5'd8, 5'd9, 16'h0);
            begin
                repeat (3) @(negedge clk);
                chk("bp_ready", bus.req_ready, 0);
                chk("bp_valid", bus.out_valid, 1);
                @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        idle(3);

        do_flush(0);
        issue(3'd0, 3'b100, 5'd1, 5'd1, 5'd1, 16'h0, 0, 32'h0);
        idle(1);
        issue(3'd7, 3'b010, 5'd1, 5'd1, 5'd1, 16'h0, 0, 32'h0);
        idle(1);
        chk("inv_no_word", bus.out_valid, 0);
        send(3'd0, 3'b111, 5'd10, 5'd11, 5'd12, 16'h0);
        idle(2);

        do_flush(0);
        for (int i = 0; i < 5; i++) send(3'd3, 3'b000, 5'(i), 5'd2, 5'd0, 16'(i));
        idle(2);
        bus.out_ready = 1'b0;
        send(3'd5, 3'b000, 5'd3, 5'd4, 5'd0, 16'h1234);
        do_flush(1);
        bus.out_ready = 1'b1;
        send(3'd0, 3'b110, 5'd1, 5'd2, 5'd3, 16'h0);
        idle(2);

        do_flush(0);
        bus.out_ready = 1'b0;
        send(3'd0, 3'b011, 5'd1, 5'd2, 5'd3, 16'h0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst", bus.out_valid, 0);
        sbq.delete();
        errq.delete();
        mcnt = 0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);
        send(3'd2, 3'b000, 5'd2, 5'd3, 5'd0, 16'h0010);
        idle(2);

        rr = 1'b1;
        fork
            while (rr) begin
                @(posedge clk);
                #1;
                if (rr) bus.out_ready = ($urandom % 4) != 0;
            end
        join_none
        for (int i = 0; i < 400; i++) begin
            if ($urandom % 40 == 0) do_flush($urandom % 2 == 1);
            send(3'($urandom), 3'($urandom), 5'($urandom), 5'($urandom),
                 5'($urandom), 16'($urandom));
            if ($urandom % 3 == 0) idle(1);
        end
        rr = 1'b0;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (sbq.size() == 0 && errq.size() == 0) break;
            idle(1);
        end
        chk("drain_words", sbq.size(), 0);
        chk("drain_errs", errq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
